// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready producers.
// Tracks a shadow occupancy so no write can overflow, and raises a hysteretic watermark irq.
module fifo_wr_arbiter #(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   parameter int DEPTH = 16,
   parameter int HI_WM = 12,
   parameter int LO_WM = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic [N-1:0]               req_valid,
   input  logic [N*WIDTH-1:0]         req_data,
   output logic [N-1:0]               req_ready,
   output logic                       fifo_wr_en,
   output logic [WIDTH-1:0]           fifo_data_in,
   input  logic                       fifo_rd_en,
   input  logic                       fifo_empty,
   input  logic                       fifo_full,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [$clog2(N)-1:0]       grant_id,
   output logic                       wm_irq,
   output logic                       ovf_err
);
   localparam int OW = $clog2(DEPTH+1);
   localparam int GW = $clog2(N);
   localparam logic [OW-1:0] C_DEPTH    = OW'(DEPTH);
   localparam logic [OW-1:0] C_HI       = OW'(HI_WM);
   localparam logic [OW-1:0] C_LO       = OW'(LO_WM);
   localparam logic [OW:0]   C_DEPTH_P  = (OW+1)'(DEPTH);
   localparam logic [OW:0]   C_DEPTH_M1 = (OW+1)'(DEPTH-1);
   localparam logic [GW:0]   C_N        = (GW+1)'(N);
   localparam logic [GW-1:0] C_LAST     = GW'(N-1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_wr_en;
   logic [WIDTH-1:0]  r_data;
   logic [OW-1:0]     r_occ;
   logic [GW-1:0]     r_grant_id;
   logic              r_wm;
   logic              r_ovf;

   logic [OW:0]       w_pending;
   logic              w_can_issue;
   logic              w_found;
   logic [GW-1:0]     w_winner;
   logic [GW:0]       w_sum;
   logic [N-1:0]      w_onehot;
   logic              w_xfer;
   logic              w_inc;
   logic              w_dec;
   logic [WIDTH-1:0]  w_data;

   // Pending includes the word already on its way into the FIFO.
   assign w_pending   = {1'b0, r_occ} + {{OW{1'b0}}, r_wr_en};
   assign w_can_issue = rst_n & en & (r_state == ARB) & (w_pending < C_DEPTH_P);
   assign req_ready   = w_onehot & {N{w_can_issue & w_found}};
   assign w_xfer      = w_can_issue & w_found;
   assign w_inc       = r_wr_en & ~fifo_full;
   assign w_dec       = fifo_rd_en & ~fifo_empty;
   assign w_data      = req_data[w_winner*WIDTH +: WIDTH];

   // Rotating priority search starting just after the last granted producer
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_grant_id;
      w_sum    = '0;
      for (int k = 1; k <= N; k++) begin
         w_sum = {1'b0, r_grant_id} + (GW+1)'(k);
         if (w_sum >= C_N) begin
            w_sum = w_sum - C_N;
         end else begin
            w_sum = w_sum;
         end
         if (!w_found && req_valid[w_sum[GW-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_sum[GW-1:0];
         end else begin
            w_found  = w_found;
            w_winner = w_winner;
         end
      end
   end

   // One-hot decode of the search winner
   always_comb begin
      w_onehot           = '0;
      w_onehot[w_winner] = 1'b1;
   end

   // Next-state: stall once the granted word will fill the FIFO
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (en) w_state_nxt = ARB;
            else    w_state_nxt = IDLE;
         end
         ARB: begin
            if (!en)                                    w_state_nxt = IDLE;
            else if (w_xfer && w_pending >= C_DEPTH_M1) w_state_nxt = STALL;
            else if (w_pending >= C_DEPTH_P)            w_state_nxt = STALL;
            else                                        w_state_nxt = ARB;
         end
         STALL: begin
            if (!en)                          w_state_nxt = IDLE;
            else if (w_pending < C_DEPTH_P)   w_state_nxt = ARB;
            else                              w_state_nxt = STALL;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Write strobe, data and last-grant registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_en    <= 1'b0;
         r_data     <= '0;
         r_grant_id <= C_LAST;
      end else begin
         r_wr_en <= w_xfer;
         if (w_xfer) begin
            r_data     <= w_data;
            r_grant_id <= w_winner;
         end
      end
   end

   // Shadow occupancy, watermark hysteresis and sticky overflow flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_occ <= '0;
         r_wm  <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         if (w_inc && !w_dec && r_occ != C_DEPTH)       r_occ <= r_occ + {{(OW-1){1'b0}}, 1'b1};
         else if (w_dec && !w_inc && r_occ != {OW{1'b0}}) r_occ <= r_occ - {{(OW-1){1'b0}}, 1'b1};
         if (r_occ >= C_HI)      r_wm <= 1'b1;
         else if (r_occ <= C_LO) r_wm <= 1'b0;
         if (r_wr_en && fifo_full) r_ovf <= 1'b1;
      end
   end

   assign fifo_wr_en   = r_wr_en;
   assign fifo_data_in = r_data;
   assign occupancy    = r_occ;
   assign grant_id     = r_grant_id;
   assign wm_irq       = r_wm;
   assign ovf_err      = r_ovf;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter: the bench plays the FIFO, predicts
// round-robin winners and words, and a separate monitor checks every registered output.
module tb_fifo_wr_arbiter;
   localparam int W = 16, N = 4, D = 16, HI = 12, LO = 4;

   logic           clk = 1'b0;
   logic           rst_n, en, fifo_rd_en, fifo_empty, fifo_full;
   logic [N-1:0]   req_valid, req_ready;
   logic [N*W-1:0] req_data;
   logic           fifo_wr_en, wm_irq, ovf_err;
   logic [W-1:0]   fifo_data_in;
   logic [4:0]     occupancy;
   logic [1:0]     grant_id;

   int           checks = 0, failures = 0;
   int           m_count = 0, m_last = N-1, starve = 0, rst_gen = 0, mon_gen = 0;
   bit           m_wm = 0, m_inflight = 0, mon_on = 0;
   logic [W-1:0] last_data = '0;
   logic [W-1:0] sb_q[$];

   fifo_wr_arbiter #(.WIDTH(W), .N(N), .DEPTH(D), .HI_WM(HI), .LO_WM(LO)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
      .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .occupancy(occupancy), .grant_id(grant_id), .wm_irq(wm_irq), .ovf_err(ovf_err));

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: registered outputs against the scoreboard and the model state
   initial begin
      logic [W-1:0] exp_w;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (mon_gen != rst_gen) begin
               mon_gen   = rst_gen;
               last_data = '0;
            end
            chk("wr_en", fifo_wr_en, sb_q.size() != 0);
            if (fifo_wr_en && sb_q.size() != 0) begin
               exp_w = sb_q.pop_front();
               chk("data_in", fifo_data_in, exp_w);
               last_data = exp_w;
            end else if (!fifo_wr_en) begin
               chk("data_hold", fifo_data_in, last_data);
            end
            chk("occupancy", occupancy, m_count);
            chk("grant_id", grant_id, m_last);
            chk("wm_irq", wm_irq, m_wm);
            chk("ovf_err", ovf_err, 0);
         end
      end
   end

   task automatic run_reset(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         rst_n = 1'b0; en = 1'b0; req_valid = '0; fifo_rd_en = 1'b0;
         fifo_full = (m_count == D); fifo_empty = (m_count == 0);
         #1;
         chk("rst_ready", req_ready, 0);
         m_count = 0; m_wm = 0; m_last = N-1; m_inflight = 0; starve = 0;
         rst_gen++;
      end
      @(posedge clk); #1;
      chk("rst_data", fifo_data_in, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      mon_on = 1;
   endtask

   task automatic run(input int cycles, input logic [N-1:0] vmask, input int vpct,
                      input int rdpct, input int enpct);
      logic [N-1:0] v, exp_mask;
      int pend, win, old;
      bit hs, inc, dec;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            v[i] = vmask[i] && ($urandom_range(99) < vpct);
            req_data[i*W +: W] = W'($urandom);
         end
         rst_n = 1'b1;
         en = ($urandom_range(99) < enpct);
         req_valid = v;
         fifo_rd_en = ($urandom_range(99) < rdpct);
         fifo_full = (m_count == D);
         fifo_empty = (m_count == 0);
         #1;
         pend = m_count + int'(m_inflight);
         win = -1;
         for (int k = 1; k <= N; k++)
            if (win < 0 && v[(m_last + k) % N]) win = (m_last + k) % N;
         exp_mask = (win < 0) ? '0 : (N'(1) << win);
         if (req_ready != '0) begin
            chk("rr_order", req_ready, exp_mask);
            chk("grant_allowed", en && pend < D, 1);
         end
         if (en && v != '0 && pend < D && req_ready == '0) starve++;
         else starve = 0;
         chk("liveness", starve > 2, 0);
         hs = (req_ready & v) != '0;
         old = m_count;
         inc = m_inflight && m_count != D;
         dec = fifo_rd_en && m_count != 0;
         m_count = m_count + int'(inc) - int'(dec);
         if (old >= HI) m_wm = 1;
         else if (old <= LO) m_wm = 0;
         m_inflight = 0;
         if (hs && win >= 0) begin
            sb_q.push_back(req_data[win*W +: W]);
            m_last = win;
            m_inflight = 1;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; req_valid = '0; req_data = '0;
      fifo_rd_en = 1'b0; fifo_empty = 1'b1; fifo_full = 1'b0;
      run_reset(2);
      run(40, 4'hF, 100, 0, 100);      // fill to full and stall
      run(1, 4'hF, 100, 100, 100);     // one read frees a slot
      run(6, 4'hF, 100, 0, 100);
      run(30, 4'h0, 0, 100, 100);      // drain through the low watermark
      run(40, 4'b0101, 100, 100, 100); // alternating pair, reads keep pace
      run(300, 4'hF, 50, 40, 90);
      run(200, 4'hF, 70, 30, 60);      // en toggling with words in flight
      run(30, 4'h0, 0, 100, 100);
      for (int g = 0; g < 40 && m_count < 7; g++) run(1, 4'hF, 100, 0, 100);
      run_reset(1);                    // reset mid-burst
      run(12, 4'hF, 100, 0, 100);
      run(400, 4'hF, 80, 55, 100);
      run(200, 4'b1010, 90, 20, 95);
      run(4, 4'h0, 0, 0, 0);
      @(negedge clk); #2;
      chk("sb_drain", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the synchronous FIFO's single write port among N producers, using a valid/ready handshake per producer.
- Keeps a shadow occupancy count of the FIFO, so it never issues a write that could overflow.
- Raises a hysteretic watermark interrupt from that count.
- Sits between the producer agents/blocks and the FIFO's wr_en/data_in inputs; observes the FIFO's rd_en/empty/full.

Parameters:
WIDTH, 16, data width of each producer word and of the FIFO data_in
N, 4, number of requesters (2..8)
DEPTH, 16, FIFO capacity in words
HI_WM, 12, occupancy at or above which wm_irq sets
LO_WM, 4, occupancy at or below which wm_irq clears (LO_WM < HI_WM)

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
en  input  1  arbitration enable
req_valid  input  N  producer i has a word
req_data  input  N*WIDTH  producer i word in bits [i*WIDTH +: WIDTH]
req_ready  output  N  one-hot grant; transfer when req_valid[i] & req_ready[i]
fifo_wr_en  output  1  registered FIFO write strobe
fifo_data_in  output  WIDTH  registered FIFO write data
fifo_rd_en  input  1  FIFO read strobe (monitored)
fifo_empty  input  1  FIFO empty flag
fifo_full  input  1  FIFO full flag
occupancy  output  $clog2(DEPTH+1)  shadow word count
grant_id  output  $clog2(N)  index of last granted producer
wm_irq  output  1  watermark interrupt, level
ovf_err  output  1  sticky: write issued while fifo_full

Behaviour:
- Reset (rst_n=0 at posedge): fifo_wr_en=0, fifo_data_in=0, occupancy=0, grant_id=N-1 (so producer 0 wins first), wm_irq=0, ovf_err=0, state=IDLE. Reset mid-transfer drops the in-flight word.
- req_ready is combinational from state, pointer and req_valid; it is 0 during reset.
- Occupancy update: inc = fifo_wr_en & ~fifo_full; dec = fifo_rd_en & ~fifo_empty; occupancy <= occupancy + inc - dec. A simultaneous inc and dec leaves it unchanged. The count saturates at 0 and DEPTH and never wraps.
- Pending = occupancy + fifo_wr_en, covering the word in flight. Issue is allowed only when pending < DEPTH.
- FSM:
  - IDLE: en=0; no grants. IDLE -> ARB when en=1.
  - ARB: issue allowed. ARB -> STALL when a grant makes pending reach DEPTH, or when pending == DEPTH. ARB -> IDLE when en=0.
  - STALL: no grants. STALL -> ARB when pending < DEPTH and en=1. STALL -> IDLE when en=0.
  - Deasserting en never cancels an in-flight word.
- Arbitration (ARB, issue allowed): search req_valid starting at grant_id+1 modulo N. The first set bit wins and gets req_ready[winner]=1; all others stay 0.
- Latency on a transfer: the next cycle has fifo_wr_en=1 and fifo_data_in=that word (one-cycle latency); grant_id <= winner.
- With no transfer, fifo_wr_en=0 and fifo_data_in holds its previous value.
- Throughput: one word per cycle. A continuously valid producer set is served 0,1,...,N-1,0,...
- A producer dropping valid without being granted is legal; no state changes.
- wm_irq: sets the cycle after occupancy >= HI_WM; clears the cycle after occupancy <= LO_WM; otherwise holds.
- ovf_err: sets on fifo_wr_en & fifo_full and stays set until reset. It must never fire when DEPTH matches the FIFO.

Test Plan:
- Reset, then en=1 with req_valid=4'b1111 and no reads -> grants 0,1,2,3,0,... one per cycle; fifo_wr_en high from cycle 2; after 16 writes occupancy=16, state STALL, req_ready=0, ovf_err=0.
- Full FIFO, then one fifo_rd_en pulse -> occupancy 16->15; next cycle one grant to the next producer in rotation; occupancy returns to 16.
- req_valid=4'b0101 continuous with reads matching writes -> grants alternate 0,2,0,2; occupancy constant; producers 1 and 3 never see req_ready.
- Fill to 12 -> wm_irq=1 the cycle after occupancy=12; drain to 5 -> still 1; drain to 4 -> wm_irq=0 the next cycle.
- Deassert en while a grant is in flight -> that word is written (fifo_wr_en=1 once more); no further grants; state IDLE; re-enable resumes at grant_id+1.
- Assert rst_n=0 for one cycle mid-burst at occupancy=7 -> all outputs go to reset values the next cycle; the first grant after reset goes to producer 0.
